// File: rtl/inv_sub_bytes_seq.sv
// Inverse AES SubBytes sequencer: LANES inverse S-box lookups per cycle, result after 16/LANES cycles.
// Result holds in DONE until out_ready; a new block can be accepted on the same edge that drains it.
module inv_sub_bytes_seq #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int GROUPS = 16 / LANES;
  localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [127:0]    r_work;
  logic [127:0]    w_upd;
  logic            w_last;
  logic            w_load;

  assign w_last    = (r_cnt == CW'(GROUPS - 1));
  assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_load    = in_valid && in_ready;
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_state = r_work;

  // Lane l substitutes byte r_cnt*LANES+l; byte 0 sits in the MSBs.
  always_comb begin
    w_upd = r_work;
    for (int l = 0; l < LANES; l++) begin
      w_upd[127 - 8*(int'(r_cnt)*LANES + l) -: 8] =
        INV_SBOX[r_work[127 - 8*(int'(r_cnt)*LANES + l) -: 8]];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = in_valid ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_work  <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_work <= in_state;
        r_cnt  <= '0;
      end else if (r_state == RUN) begin
        r_work <= w_upd;
        r_cnt  <= w_last ? '0 : r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: LANES=4 main instance plus a sweep of LANES=1,2,8,16.
// Reference model derives the inverse S-box from GF(2^8) arithmetic and the inverse affine map.
module tb_inv_sub_bytes_seq;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  logic         sw_in_valid;
  logic [127:0] sw_in_state;
  logic         sw_out_ready;
  logic         sw_in_ready  [4];
  logic         sw_out_valid [4];
  logic [127:0] sw_out_state [4];
  logic         sw_busy      [4];

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  inv_sub_bytes_seq #(.LANES(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
    .busy(busy)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sw
    inv_sub_bytes_seq #(.LANES(g < 2 ? (1 << g) : (1 << (g + 1)))) u_sw (
      .clk(clk), .rst_n(rst_n),
      .in_valid(sw_in_valid), .in_ready(sw_in_ready[g]), .in_state(sw_in_state),
      .out_valid(sw_out_valid[g]), .out_ready(sw_out_ready), .out_state(sw_out_state[g]),
      .busy(sw_busy[g])
    );
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    if (a == 8'h00) return 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(a, 8'(y)) == 8'h01) return 8'(y);
    return 8'h00;
  endfunction

  function automatic logic [7:0] ref_isbox(input logic [7:0] x);
    logic [7:0] t;
    t = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return ginv(t);
  endfunction

  function automatic logic [127:0] ref_block(input logic [127:0] s);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[127 - 8*b -: 8] = ref_isbox(s[127 - 8*b -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accepts one block on the main DUT, counts edges to out_valid, then drains it.
  task automatic run_block(input logic [127:0] st, output int lat, output logic [127:0] res);
    in_state = st;
    in_valid = 1'b1;
    chk("accept_in_ready", 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0;
    in_state = rand128();
    chk("run_busy", 128'(busy), 128'd1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    res = out_state;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("drain_idle", {126'd0, out_valid, busy}, 128'd0);
  endtask

  typedef struct {
    logic [127:0] din;
    logic [127:0] dexp;
  } vec_t;

  vec_t         vt [10];
  int           lat;
  logic [127:0] res;
  logic [127:0] q [$];
  int           sent, got;
  logic         acc, dq;
  int           sw_lat [4];
  int           sw_exp [4];

  initial begin
    vt[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h52096ad53036a538bf40a39e81f3d7fb};
    vt[1] = '{{16{8'h01}}, {16{8'h09}}};
    vt[2] = '{{16{8'hff}}, {16{8'h7d}}};
    vt[3] = '{{16{8'h63}}, {16{8'h00}}};
    for (int i = 4; i < 10; i++) begin
      vt[i].din  = rand128();
      vt[i].dexp = ref_block(vt[i].din);
    end
    sw_exp = '{16, 8, 2, 1};

    rst_n = 1'b0; in_valid = 1'b0; in_state = '0; out_ready = 1'b0;
    sw_in_valid = 1'b0; sw_in_state = '0; sw_out_ready = 1'b0;

    // Reset state
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_out_state", out_state, 128'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 128'(in_ready), 128'd1);

    // Table vectors: result and 4-cycle latency
    for (int i = 0; i < 10; i++) begin
      run_block(vt[i].din, lat, res);
      chk($sformatf("vec%0d_lat", i), 128'(lat), 128'd4);
      chk($sformatf("vec%0d_out", i), res, vt[i].dexp);
    end

    // Backpressure, then back-to-back handoff
    in_state = {16{8'h63}};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    chk("bp_lat", 128'(lat), 128'd4);
    in_valid = 1'b1;
    in_state = rand128();
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp_hold_valid%0d", c), 128'(out_valid), 128'd1);
      chk($sformatf("bp_hold_state%0d", c), out_state, 128'd0);
      chk($sformatf("bp_in_ready%0d", c), 128'(in_ready), 128'd0);
      tick();
    end
    in_state  = {16{8'hff}};
    out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", 128'(in_ready), 128'd1);
    tick();
    in_valid = 1'b0; out_ready = 1'b0; in_state = rand128();
    chk("b2b_handoff", {126'd0, out_valid, busy}, 128'd1);
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    chk("b2b_lat", 128'(lat), 128'd4);
    chk("b2b_out", out_state, {16{8'hff}} ^ {16{8'h82}});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset during RUN discards the block
    in_state = rand128();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_out_state", out_state, 128'd0);
    tick(); tick();
    rst_n = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid || busy) acc = 1'b1;
    end
    chk("midrst_discarded", 128'(acc), 128'd0);
    run_block({16{8'h01}}, lat, res);
    chk("midrst_next_lat", 128'(lat), 128'd4);
    chk("midrst_next_out", res, {16{8'h09}});

    // Random streaming with random backpressure against the model
    sent = 0; got = 0;
    in_state = rand128();
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 3000 && got < 24; cyc++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      dq  = out_valid && out_ready;
      if (dq) begin
        if (q.size() == 0) chk("stream_spurious", 128'd1, 128'd0);
        else chk($sformatf("stream%0d", got), out_state, q.pop_front());
        got++;
      end
      if (acc) begin
        q.push_back(ref_block(in_state));
        sent++;
      end
      tick();
      if (acc) begin
        in_valid = (sent < 24) && ($urandom % 4 != 0);
        in_state = rand128();
      end else if (!in_valid && sent < 24) begin
        in_valid = ($urandom % 2 == 1);
        in_state = rand128();
      end
      out_ready = ($urandom % 3 != 0);
    end
    chk("stream_count", 128'(got), 128'd24);
    in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();

    // LANES sweep: same vector, latency 16/LANES
    sw_lat = '{0, 0, 0, 0};
    sw_in_state = vt[0].din;
    sw_in_valid = 1'b1;
    tick();
    sw_in_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      for (int g = 0; g < 4; g++)
        if (sw_out_valid[g] && sw_lat[g] == 0) sw_lat[g] = c;
    end
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("sweep%0d_lat", g), 128'(sw_lat[g]), 128'(sw_exp[g]));
      chk($sformatf("sweep%0d_out", g), sw_out_state[g], vt[0].dexp);
    end
    sw_out_ready = 1'b1;
    tick();
    sw_out_ready = 1'b0;
    for (int g = 0; g < 4; g++)
      chk($sformatf("sweep%0d_idle", g), {126'd0, sw_busy[g], sw_in_ready[g]}, 128'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
